// File: rtl/watchdog_timer_unit_if.sv
// Control/status bundle between the host control block and the liveness watchdog.
// The controller side drives arming and kicks; the watchdog side reports status.
interface watchdog_timer_unit_if;
  logic enable;
  logic heartbeat;
  logic force_reset;
  logic warning;

  modport master (
    output enable,
    output heartbeat,
    input  force_reset,
    input  warning
  );

  modport slave (
    input  enable,
    input  heartbeat,
    output force_reset,
    output warning
  );
endinterface

// File: rtl/watchdog_timer_unit.sv
// Liveness watchdog: counts cycles since the last heartbeat and raises a sticky
// warning, then a sticky force_reset request, when the controller goes quiet.
module watchdog_timer_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 625_000_000,
  parameter int unsigned WARNING_CYCLES = 500_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  watchdog_timer_unit_if.slave  wd
);

  logic [31:0] counter;
  logic [31:0] counter_inc;
  logic        warning_q;
  logic        triggered;

  // counter never exceeds TIMEOUT_CYCLES < 2^32-1, so the increment cannot wrap
  assign counter_inc = counter + 32'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter   <= '0;
      warning_q <= 1'b0;
      triggered <= 1'b0;
    end else if (!wd.enable || wd.heartbeat) begin
      counter   <= '0;
      warning_q <= 1'b0;
      triggered <= 1'b0;
    end else if (counter < TIMEOUT_CYCLES) begin
      counter   <= counter_inc;
      warning_q <= warning_q | (counter_inc >= WARNING_CYCLES);
      triggered <= triggered | (counter_inc >= TIMEOUT_CYCLES);
    end else begin
      // saturated: hold the count, both flags stay asserted
      counter   <= counter;
      warning_q <= 1'b1;
      triggered <= 1'b1;
    end
  end

  assign wd.force_reset = triggered;
  assign wd.warning     = warning_q;

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Directed bench for watchdog_timer_unit with TIMEOUT_CYCLES=20, WARNING_CYCLES=10.
module tb_watchdog_timer_unit;
  localparam int TO = 20;
  localparam int WN = 10;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  watchdog_timer_unit_if wd_if ();

  watchdog_timer_unit #(
    .TIMEOUT_CYCLES(TO),
    .WARNING_CYCLES(WN)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .wd  (wd_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wd_if.enable = 1'b1;
    wd_if.heartbeat = 1'b0;
    step(1);
    total++;
    if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got fr=%b warn=%b cnt=%0d want 0/0/0",
               wd_if.force_reset, wd_if.warning, dut.counter);
    end
    rstn = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      step(1);
      total++;
      if (dut.counter !== 32'(i) || wd_if.warning !== (i >= WN) || wd_if.force_reset !== (i >= TO)) begin
        bad++;
        $display("[TB] FAIL count_edge%0d got cnt=%0d warn=%b fr=%b want cnt=%0d warn=%b fr=%b",
                 i, dut.counter, wd_if.warning, wd_if.force_reset, i, (i >= WN), (i >= TO));
      end
    end
    step(10);
    total++;
    if (dut.counter !== 32'd20 || wd_if.warning !== 1'b1 || wd_if.force_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL saturate got cnt=%0d warn=%b fr=%b want cnt=20 warn=1 fr=1",
               dut.counter, wd_if.warning, wd_if.force_reset);
    end
  endtask

  task automatic kick();
    wd_if.heartbeat = 1'b1;
    step(1);
    wd_if.heartbeat = 1'b0;
  endtask

  task automatic test_kick();
    kick();
    step(15);
    total++;
    if (dut.counter !== 32'd15 || wd_if.warning !== 1'b1 || wd_if.force_reset !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pre_kick got cnt=%0d warn=%b fr=%b want 15/1/0",
               dut.counter, wd_if.warning, wd_if.force_reset);
    end
    kick();
    total++;
    if (dut.counter !== 32'd0 || wd_if.warning !== 1'b0 || wd_if.force_reset !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_kick got cnt=%0d warn=%b fr=%b want 0/0/0",
               dut.counter, wd_if.warning, wd_if.force_reset);
    end
    step(19);
    total++;
    if (dut.counter !== 32'd19 || wd_if.force_reset !== 1'b0) begin
      bad++;
      $display("[TB] FAIL kick_edge19 got cnt=%0d fr=%b want 19/0", dut.counter, wd_if.force_reset);
    end
    step(1);
    total++;
    if (wd_if.force_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL kick_edge20 got fr=%b want 1", wd_if.force_reset);
    end
  endtask

  task automatic test_disable_reset();
    wd_if.enable = 1'b0;
    step(1);
    total++;
    if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
      bad++;
      $display("[TB] FAIL disabled got fr=%b warn=%b cnt=%0d want 0/0/0",
               wd_if.force_reset, wd_if.warning, dut.counter);
    end
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      total++;
      if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
        bad++;
        $display("[TB] FAIL in_reset%0d got fr=%b warn=%b cnt=%0d want 0/0/0",
                 i, wd_if.force_reset, wd_if.warning, dut.counter);
      end
    end
    rstn = 1'b1;
    wd_if.enable = 1'b1;
    step(19);
    total++;
    if (dut.counter !== 32'd19 || wd_if.force_reset !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rearm_edge19 got cnt=%0d fr=%b want 19/0", dut.counter, wd_if.force_reset);
    end
    step(1);
    total++;
    if (wd_if.force_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rearm_edge20 got fr=%b want 1", wd_if.force_reset);
    end
  endtask

  task automatic test_kick_at_timeout();
    kick();
    step(19);
    total++;
    if (dut.counter !== 32'd19 || wd_if.force_reset !== 1'b0) begin
      bad++;
      $display("[TB] FAIL race_pre got cnt=%0d fr=%b want 19/0", dut.counter, wd_if.force_reset);
    end
    kick();
    total++;
    if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
      bad++;
      $display("[TB] FAIL race_kick got fr=%b warn=%b cnt=%0d want 0/0/0",
               wd_if.force_reset, wd_if.warning, dut.counter);
    end
  endtask

  task automatic test_async_reset();
    step(20);
    total++;
    if (wd_if.force_reset !== 1'b1 || wd_if.warning !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_pre got fr=%b warn=%b want 1/1", wd_if.force_reset, wd_if.warning);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
      bad++;
      $display("[TB] FAIL async_clear got fr=%b warn=%b cnt=%0d want 0/0/0",
               wd_if.force_reset, wd_if.warning, dut.counter);
    end
    step(1);
    rstn = 1'b1;
  endtask

  task automatic test_disabled_idle();
    wd_if.enable = 1'b0;
    wd_if.heartbeat = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      total++;
      if (wd_if.force_reset !== 1'b0 || wd_if.warning !== 1'b0 || dut.counter !== 32'd0) begin
        bad++;
        $display("[TB] FAIL idle_edge%0d got fr=%b warn=%b cnt=%0d want 0/0/0",
                 i, wd_if.force_reset, wd_if.warning, dut.counter);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    wd_if.enable = 1'b0;
    wd_if.heartbeat = 1'b0;
    $display("[TB] starting watchdog_timer_unit bench");
    test_reset();
    test_kick();
    test_disable_reset();
    test_kick_at_timeout();
    test_async_reset();
    test_disabled_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
